// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: BCD mm:ss.cc live count, lap freeze register and a
// run/pause/lap/clear state machine. Every output comes straight from a flop.
module stopwatch_ctrl #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic [7:0] o_disp_cs,
  output logic [7:0] o_disp_sec,
  output logic [7:0] o_disp_min,
  output logic [1:0] o_state,
  output logic       o_running,
  output logic       o_overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_LAP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = 24'h59_59_99;

  state_e    state_q,    state_d;
  bcd_time_t live_q,     live_d;
  bcd_time_t lap_q,      lap_d;
  bcd_time_t disp_q,     disp_d;
  logic      overflow_q, overflow_d;
  logic      running_q,  running_d;
  logic      count_en;
  logic      clear_ok;
  logic      lap_ok;

  // Two-digit BCD increment that rolls over to 00 after {tens_max, 9}.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] == tens_max) return 8'h00;
    return {v[7:4] + 4'd1, 4'h0};
  endfunction

  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t r;
    r    = t;
    r.cs = bcd_inc(t.cs, 4'd9);
    if (t.cs == 8'h99) begin
      r.sec = bcd_inc(t.sec, 4'd5);
      if (t.sec == 8'h59) r.min = bcd_inc(t.min, 4'd5);
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave a latch.
    state_d    = state_q;
    live_d     = live_q;
    lap_d      = lap_q;
    overflow_d = overflow_q;

    // Ticks count against the state held before this edge, so a tick that
    // arrives with the command leaving RUN still counts and one entering RUN does not.
    count_en = i_tick && (state_q == S_RUN || state_q == S_LAP);
    clear_ok = i_clear && (state_q == S_IDLE || state_q == S_PAUSED);
    lap_ok   = i_lap && (state_q == S_RUN || state_q == S_LAP);

    if (count_en) begin
      if (live_q == TIME_MAX) begin
        overflow_d = 1'b1;
        if (WRAP_EN) live_d = '0;
        else         live_d = TIME_MAX;
      end else begin
        live_d = time_inc(live_q);
      end
    end

    if (clear_ok) begin
      state_d    = S_IDLE;
      live_d     = '0;
      lap_d      = '0;
      overflow_d = 1'b0;
    end else if (i_start_stop) begin
      case (state_q)
        S_IDLE, S_PAUSED: state_d = S_RUN;
        default:          state_d = S_PAUSED;
      endcase
    end else if (lap_ok) begin
      if (state_q == S_RUN) begin
        state_d = S_LAP;
        lap_d   = live_q;
      end else begin
        state_d = S_RUN;
      end
    end

    running_d = (state_d == S_RUN) || (state_d == S_LAP);
    disp_d    = (state_d == S_LAP) ? lap_d : live_d;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking so every flop samples the pre-edge values of the others.
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
    end
  end

  assign o_disp_cs  = disp_q.cs;
  assign o_disp_sec = disp_q.sec;
  assign o_disp_min = disp_q.min;
  assign o_state    = state_q;
  assign o_running  = running_q;
  assign o_overflow = overflow_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter WRAP_EN, default 1: 1 = wrap to 00:00.00 after 59:59.99; 0 = saturate at 59:59.99.
REQ-002 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous and active-low.
REQ-004 i_tick  input  1  single-cycle 10 ms tick from the tick generator; one pulse = one centisecond.
REQ-005 i_start_stop  input  1  single-cycle command pulse, already debounced.
REQ-006 i_lap  input  1  single-cycle command pulse, already debounced.
REQ-007 i_clear  input  1  single-cycle command pulse, already debounced.
REQ-008 o_disp_cs  output  8  displayed centiseconds, two BCD digits 00-99, [7:4] = tens.
REQ-009 o_disp_sec  output  8  displayed seconds, two BCD digits 00-59.
REQ-010 o_disp_min  output  8  displayed minutes, two BCD digits 00-59.
REQ-011 o_state  output  2  state encoding: IDLE=0, RUN=1, PAUSED=2, LAP=3.
REQ-012 o_running  output  1  high in RUN or LAP.
REQ-013 o_overflow  output  1  sticky flag: the count reached the 59:59.99 boundary.

Function
REQ-014 The block SHALL hold a live count (cs, sec, min; BCD) and a lap register of the same format.
REQ-015 The live count SHALL advance by one centisecond on each cycle with i_tick=1 and state RUN or LAP, visible the next cycle.
REQ-016 Ticks in IDLE or PAUSED SHALL be ignored.
REQ-017 Carry rules SHALL be:
  - cs 99 -> 00 with sec+1.
  - sec 59 -> 00 with min+1.
  - Each BCD low digit 9 -> 0 with a tens increment.
  - No digit SHALL ever hold a non-BCD value.
REQ-018 At 59:59.99 with a counted tick:
  - WRAP_EN=1: count becomes 00:00.00 and o_overflow sets.
  - WRAP_EN=0: count holds 59:59.99, o_overflow sets, and the state is unchanged.
REQ-019 Transitions SHALL be (unlisted command/state combinations ignored):
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUN, resuming from the held count.
  - RUN + lap -> LAP, capturing the live count into the lap register.
  - LAP + lap -> RUN, releasing the freeze.
  - LAP + start_stop -> PAUSED, releasing the freeze.
  - IDLE or PAUSED + clear -> IDLE, with live count, lap register and o_overflow all zero.
REQ-020 i_clear in RUN or LAP SHALL be ignored.
REQ-021 Simultaneous commands SHALL be prioritised clear > start_stop > lap; only the highest valid command acts in a cycle.
REQ-022 A command coinciding with i_tick SHALL be evaluated against the current state:
  - Leaving RUN/LAP: that tick is still counted.
  - Entering RUN from IDLE/PAUSED: that tick is not counted.
REQ-023 The lap capture SHALL take the registered live count before that cycle's tick increment.
REQ-024 Display outputs SHALL equal the lap register in LAP and the live count in every other state; the display switches the cycle after the state change.
REQ-025 In LAP the live count SHALL keep advancing while the display stays frozen.
REQ-026 All outputs SHALL be driven from registers or from a mux of registers; there is no combinational path from any input to any output.

Reset
REQ-027 While i_rst_n=0 at a rising edge, the block SHALL load, the next cycle:
  - state IDLE;
  - live count and lap register 00:00.00;
  - o_overflow=0, o_running=0, o_state=0;
  - all display outputs 8'h00.
REQ-028 Reset SHALL override every other input, including mid-count in RUN or LAP.

Verification
REQ-029 Basic count: start_stop, then 150 ticks -> display 00:01.50, o_state=1, o_running=1.
REQ-030 Pause: start_stop at count 00:01.50, then 20 ticks -> display stays 00:01.50; start_stop, then 1 tick -> 00:01.51.
REQ-031 Lap: lap at live 00:02.00, then 300 ticks -> display 00:02.00 and live 00:05.00; lap again -> display 00:05.00 the next cycle.
REQ-032 Boundary: preload via 359999 ticks, then 1 more tick:
  - WRAP_EN=1 -> display 00:00.00, o_overflow=1.
  - WRAP_EN=0 -> display 59:59.99, o_overflow=1.
REQ-033 Simultaneous events and reset:
  - In PAUSED, clear + start_stop in the same cycle -> IDLE with count 00:00.00.
  - In RUN, clear -> ignored.
  - i_rst_n=0 in LAP -> all outputs zero the next cycle.
